// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage. Handles reset vector, flush
// redirect, branch redirect and a one-entry buffer for branches seen during a stall.
module pc_gen #(
   parameter int                 ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'hBFC0_0000,
   parameter int                 INST_BYTES   = 4,
   parameter int                 STALL_W      = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STALL_W-1:0]  stall,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   flush_pc,
   input  logic                branch_flag_i,
   input  logic [ADDR_W-1:0]   branch_target_address_i,
   output logic [ADDR_W-1:0]   pc,
   output logic                ce,
   output logic                pc_misaligned,
   output logic                redirect_pending
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ce_q, ce_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              misaligned_q, misaligned_d;

   // Only the PC-stage bit of the stall vector matters here.
   logic unused_stall;
   assign unused_stall = ^stall;

   always_comb begin
      pc_d         = pc_q;
      ce_d         = 1'b1;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      if (ce_q) begin
         if (flush) begin
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
         end else if (stall[0]) begin
            if (branch_flag_i) begin
               pend_valid_d = 1'b1;
               pend_addr_d  = branch_target_address_i;
            end
         end else if (branch_flag_i) begin
            pc_d         = branch_target_address_i;
            pend_valid_d = 1'b0;
         end else if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
         end else begin
            pc_d = pc_q + STEP;
         end
      end
      // Flag tracks the value pc is about to take, so it lines up with pc.
      misaligned_d = ce_d && ((pc_d & ALIGN_MASK) != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_VECTOR;
         ce_q         <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ce_q         <= ce_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign pc               = pc_q;
   assign ce               = ce_q;
   assign pc_misaligned    = misaligned_q;
   assign redirect_pending = pend_valid_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS fetch stage; successor to the fixed 32-bit PC register. Produces the instruction fetch address and fetch enable. Adds a configurable reset vector, address width and instruction step, an exception flush redirect with priority over branches, and a one-entry pending-redirect buffer so that a branch resolved during a fetch stall is not lost. Sits ahead of the instruction ROM/cache and is driven by the pipeline controller (stall, flush) and the decode stage (branch).

## Interface

- ADDR_W, 32: PC width in bits.
- RESET_VECTOR, 32'hBFC0_0000: first fetch address after reset; ADDR_W bits.
- INST_BYTES, 4: sequential increment; power of two, at least 1.
- STALL_W, 6: stall vector width; only bit 0 (PC stage) is used.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 freezes the PC.
- flush  in  1  exception/eret redirect request.
- flush_pc  in  ADDR_W  flush target.
- branch_flag_i  in  1  branch/jump taken.
- branch_target_address_i  in  ADDR_W  branch target.
- pc  out  ADDR_W  fetch address.
- ce  out  1  fetch enable; pc is valid only when ce=1.
- pc_misaligned  out  1  pc low log2(INST_BYTES) bits are non-zero while ce=1.
- redirect_pending  out  1  pending-redirect buffer is occupied.

## Operation

- Reset (rst=1 at an edge): ce←0, pc←RESET_VECTOR, pending cleared (redirect_pending←0), pc_misaligned←0. rst overrides all other inputs.
- Start-up: ce←1 at the first edge with rst=0. pc holds RESET_VECTOR and all inputs are ignored while ce=0 at the edge, so the first enabled fetch is RESET_VECTOR.
- When ce=1 at the edge, actions are evaluated in priority order:
  1. flush=1: pc←flush_pc and pending cleared. Applies regardless of stall or branch_flag_i.
  2. stall[0]=1: pc holds. If branch_flag_i=1, the pending buffer captures branch_target_address_i; a later capture overwrites an earlier one (latest wins).
  3. Not stalled and branch_flag_i=1: pc←branch_target_address_i and pending cleared. A live branch overrides a stale pending one.
  4. Not stalled, no branch, pending occupied: pc←pending target and pending cleared.
  5. Otherwise: pc←pc+INST_BYTES.
- Arithmetic: the increment is modulo 2^ADDR_W, so all-ones minus (INST_BYTES-1) wraps to 0. No saturation and no error on wrap.
- pc_misaligned is registered and updated with pc from the new pc value. pc still takes a misaligned target; the exception logic consumes the flag. Cleared when ce=0.
- redirect_pending is the registered buffer-valid bit.

## Timing

- Redirect latency: a flush or an unstalled branch sampled at edge N makes pc equal the target after edge N, one cycle.
- A branch captured during a stall appears on pc at the first edge where stall[0]=0, unless a flush or a newer branch occurs first.
- Stall release: pc advances at the first edge with stall[0]=0. Stall has no effect on ce.
- Reset mid-operation: one edge with rst=1 restores all reset values, including dropping any pending redirect.
- flush and branch in the same cycle: flush wins and the branch is discarded, even if stalled.

## Test plan

- Reset/start-up: hold rst 3 cycles then release → ce=0 and pc=BFC00000 during reset; ce=1 with pc=BFC00000 on the first cycle after; then BFC00004, BFC00008.
- Stall plus branch: at pc=BFC00010, assert stall[0] for 3 cycles with branch_flag_i=1 and target 80000100 in cycle 2 only → pc holds BFC00010 and redirect_pending=1; the first unstalled edge gives pc=80000100 and redirect_pending=0.
- Priority: same cycle flush=1 (flush_pc=80000180), branch_flag_i=1 (target 80000200), stall[0]=1, with a pending entry present → pc=80000180 next cycle and pending cleared.
- Live branch beats pending: pending=80000040, then unstalled branch to 80000080 → pc=80000080 and pending cleared.
- Wrap and misalignment: ADDR_W=32, pc=FFFFFFFC → next pc=00000000. Branch to 80000002 → pc=80000002 and pc_misaligned=1 the same cycle; the next sequential step gives 80000006, still misaligned.
- Reset with pending: pending occupied, assert rst one cycle → pc=BFC00000, ce=0, redirect_pending=0.
